// File: rtl/sw_pkg.sv
// Shared constants and state encoding for the Smith-Waterman result collector.
package sw_pkg;

    // Score width shared with the systolic array's max/v/f outputs
    localparam int SW_DW    = 12;
    // Target symbol width (2-bit nucleotide code)
    localparam int SW_SYM_W = 2;
    // Default maximum target length (column buffer depth)
    localparam int SW_T_MAX = 1024;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESULT  = 2'd2
    } state_t;

endpackage

// File: rtl/sw_col_buf.sv
// Boundary-column buffer: one write port, one read port, registered read-first
// output so it maps onto a block RAM or SRAM macro.
module sw_col_buf #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH),
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port; contents are not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read; a same-cycle write to raddr is not visible (old data returned)
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sw_result_collector.sv
// Collects the systolic array's output column stream: tracks the best score and
// its column, buffers boundary columns for the next pass, and returns the final
// score through a valid/ready handshake.
module sw_result_collector
    import sw_pkg::*;
#(
    parameter int T_MAX = SW_T_MAX,
    parameter int DW    = SW_DW,
    parameter int CW    = $clog2(T_MAX)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CW:0]         len,
    input  logic                last_pass,
    input  logic                valid_in,
    input  logic [SW_SYM_W-1:0] t_in,
    input  logic [DW-1:0]       max_in,
    input  logic [DW-1:0]       v_in,
    input  logic [DW-1:0]       f_in,
    input  logic                rd_en,
    output logic                rd_valid,
    output logic [SW_SYM_W-1:0] rd_t,
    output logic [DW-1:0]       rd_v,
    output logic [DW-1:0]       rd_f,
    output logic                busy,
    output logic                pass_done,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DW-1:0]       res_score,
    output logic [CW-1:0]       res_col
);

    localparam int EW = SW_SYM_W + 2 * DW;

    state_t          state_reg, state_next;
    logic [CW:0]     len_reg;
    logic            last_reg;
    logic [CW:0]     col_cnt_reg;
    logic [CW-1:0]   rd_ptr_reg;
    logic [DW-1:0]   best_reg;
    logic [CW-1:0]   best_col_reg;
    logic            pass_done_reg;
    logic            rd_valid_reg;
    logic [EW-1:0]   rd_data;
    logic            end_of_pass;
    logic            col_wr;

    // Pass ends once the expected column count has been reached
    assign end_of_pass = (state_reg == ST_COLLECT) && (col_cnt_reg == len_reg);
    // Accept a column only while collecting and below the length; a restart wins
    assign col_wr = (state_reg == ST_COLLECT) && valid_in && (col_cnt_reg < len_reg) && !start;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; start restarts the pass from any state
    always_comb begin
        state_next = state_reg;
        if (start) begin
            state_next = ST_COLLECT;
        end else begin
            case (state_reg)
                ST_IDLE:    state_next = ST_IDLE;
                ST_COLLECT: if (end_of_pass) state_next = last_reg ? ST_RESULT : ST_IDLE;
                ST_RESULT:  if (res_ready) state_next = ST_IDLE;
                default:    state_next = ST_IDLE;
            endcase
        end
    end

    // State-decoded outputs; result fields are zero outside RESULT
    always_comb begin
        busy      = (state_reg == ST_COLLECT);
        res_valid = (state_reg == ST_RESULT);
        res_score = '0;
        res_col   = '0;
        if (state_reg == ST_RESULT) begin
            res_score = best_reg;
            res_col   = best_col_reg;
        end
    end

    // Pass bookkeeping: length latch, column count, best score, read pointer, pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            len_reg       <= '0;
            last_reg      <= 1'b0;
            col_cnt_reg   <= '0;
            rd_ptr_reg    <= '0;
            best_reg      <= '0;
            best_col_reg  <= '0;
            pass_done_reg <= 1'b0;
            rd_valid_reg  <= 1'b0;
        end else begin
            pass_done_reg <= end_of_pass && !last_reg && !start;
            rd_valid_reg  <= rd_en;
            if (start) begin
                len_reg      <= len;
                last_reg     <= last_pass;
                col_cnt_reg  <= '0;
                rd_ptr_reg   <= '0;
                best_reg     <= '0;
                best_col_reg <= '0;
            end else begin
                if (col_wr) begin
                    col_cnt_reg <= col_cnt_reg + (CW+1)'(1);
                    // Strict compare keeps the earliest column on ties
                    if (max_in > best_reg) begin
                        best_reg     <= max_in;
                        best_col_reg <= col_cnt_reg[CW-1:0];
                    end
                end
                if (rd_en) begin
                    rd_ptr_reg <= rd_ptr_reg + CW'(1);
                end
            end
        end
    end

    // Write address is the low bits of the column count, so it wraps modulo T_MAX
    sw_col_buf #(
        .DEPTH (T_MAX),
        .AW    (CW),
        .WIDTH (EW)
    ) u_col_buf (
        .clk   (clk),
        .rst   (rst),
        .we    (col_wr),
        .waddr (col_cnt_reg[CW-1:0]),
        .wdata ({t_in, v_in, f_in}),
        .re    (rd_en),
        .raddr (rd_ptr_reg),
        .rdata (rd_data)
    );

    assign rd_valid  = rd_valid_reg;
    assign rd_t      = rd_data[EW-1 -: SW_SYM_W];
    assign rd_v      = rd_data[2*DW-1 -: DW];
    assign rd_f      = rd_data[DW-1:0];
    assign pass_done = pass_done_reg;

endmodule

// File: doc/sw_result_collector.md
Name: sw_result_collector

Overview:
Downstream stage of the 128-PE systolic array. Consumes the array's output column stream (valid, t, max, v, f).
- Tracks the best score and the column where it occurs.
- Stores the boundary column (t, v, f) in an on-chip buffer, so the next pass over a longer query can re-feed the array.
- Presents the final score through a valid/ready result handshake after the last pass.

Parameters:
T_MAX, 1024, maximum target length (buffer depth, column count)
DW, 12, score width; matches array max/v/f width
CW, $clog2(T_MAX), column index / address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse: begin a pass
len  input  CW+1  target length for this pass, sampled on start
last_pass  input  1  sampled on start; 1 = final pass, produce result
valid_in  input  1  array output column valid
t_in  input  2  array target symbol out
max_in  input  DW  array running max out
v_in  input  DW  array H boundary out
f_in  input  DW  array F boundary out
rd_en  input  1  pop next buffered column
rd_valid  output  1  rd_t/rd_v/rd_f valid (1-cycle read latency)
rd_t  output  2  buffered target symbol
rd_v  output  DW  buffered H boundary
rd_f  output  DW  buffered F boundary
busy  output  1  state is COLLECT
pass_done  output  1  one-cycle pulse: non-final pass complete
res_valid  output  1  final result valid
res_ready  input  1  result consumer ready
res_score  output  DW  best score
res_col  output  CW  column index (0-based) of best score

Behaviour:
- Reset: state IDLE. All outputs 0. Column counter, write pointer, read pointer, best score and best column = 0. Buffer contents are don't-care.
- States: IDLE, COLLECT, RESULT.
- IDLE, start=1:
  - latch len and last_pass.
  - clear column counter, wr_ptr, rd_ptr, best=0, best_col=0.
  - go to COLLECT.
- COLLECT, each cycle with valid_in=1 and col_cnt<len:
  - write {t_in, v_in, f_in} to buffer[wr_ptr]; wr_ptr++ and col_cnt++.
  - if max_in > best (unsigned, strict): best<=max_in, best_col<=col_cnt. Ties keep the earliest column.
- Gaps (valid_in=0) are allowed in COLLECT; nothing changes.
- valid_in when not in COLLECT, or once col_cnt==len: ignored, no write.
- End of pass: the cycle col_cnt==len is observed in COLLECT.
  - last_pass=0: pulse pass_done for 1 cycle, return to IDLE.
  - last_pass=1: go to RESULT; res_valid=1 with res_score=best, res_col=best_col.
  - len=0 on start: COLLECT lasts exactly 1 cycle, then end-of-pass with best=0, col=0.
- RESULT:
  - res_valid, res_score and res_col are held stable until res_ready=1.
  - the handshake completes on res_valid & res_ready; next cycle res_valid=0, state IDLE.
- start in COLLECT or RESULT: aborts and restarts as from IDLE. res_valid drops the next cycle and pass_done is not pulsed.
- Read port (any state):
  - rd_en=1 reads buffer[rd_ptr] and increments rd_ptr.
  - next cycle rd_valid=1 with data; rd_valid=0 otherwise.
  - rd_ptr is reset by start.
  - A same-cycle read and write to the same address returns the OLD contents (read-first). This lets the next pass read while overwriting.
  - Pointers wrap modulo T_MAX. rd_en past the written length is not checked; stale data is returned.
- busy = (state==COLLECT).

Decomposition:
- Shared package sw_pkg: DW=12, symbol width 2, T_MAX default, state encoding (IDLE/COLLECT/RESULT).
- Sub-module: sw_col_buf. Single-port-write / single-port-read synchronous RAM, depth T_MAX, width 2+2*DW, read-first, registered read data. This makes the buffer mappable to an SRAM macro.

Test Plan:
- Reset then idle: all outputs 0; valid_in pulses with max_in=50 -> no write, res_valid stays 0.
- start len=4 last_pass=1; 4 valid columns with max 3,9,9,5 -> res_valid, res_score=9, res_col=1 (tie keeps earliest); held 3 cycles with res_ready=0, then drops the cycle after res_ready=1.
- start len=3 last_pass=0; columns (t,v,f)=(1,10,2),(2,11,3),(3,12,4) with 2-cycle gaps -> pass_done pulse once, no res_valid. Then 3 rd_en -> rd_valid with exactly those triples in order, 1-cycle latency.
- len=3, 5 valid columns sent -> only first 3 written/compared; a larger max_in=100 on column 4 is ignored.
- start mid-COLLECT after 2 of 4 columns, then len=2 last_pass=1 with max 7,4 -> res_score=7, res_col=0; no pass_done from the aborted pass.
- len=0 last_pass=1 -> res_valid one cycle after COLLECT entry, score 0, col 0. Separately: same-cycle rd_en and write at address 0 returns the prior pass's value.
